// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the IF stage and the
// memory controller's instruction port; misses are filled and forwarded, and a jump drops them.
module icache #(
  parameter int INDEX_W = 7,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_jump,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [ADDR_W-1:0] if_inst,
  output logic              if_rdy,
  input  logic              mem_needed,
  output logic              inst_needed,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [ADDR_W-1:0] inst_data,
  input  logic              inst_rdy
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic              first_cycle;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [ADDR_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic               fill;
  logic               unused_lsbs;

  assign req_index   = if_addr[INDEX_W+1:2];
  assign req_tag     = if_addr[ADDR_W-1:INDEX_W+2];
  assign unused_lsbs = ^if_addr[1:0];

  // The held miss address doubles as the latched index/tag for the fill.
  assign fill_index = inst_addr[INDEX_W+1:2];
  assign fill_tag   = inst_addr[ADDR_W-1:INDEX_W+2];

  assign hit  = valid[req_index] && (tag_mem[req_index] == req_tag);
  assign fill = !rst && (state == FETCH) && !first_cycle && !is_jump && inst_rdy;

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= inst_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      if_rdy      <= 1'b0;
      if_inst     <= '0;
      inst_needed <= 1'b0;
      inst_addr   <= '0;
      first_cycle <= 1'b0;
      state       <= IDLE;
    end else begin
      if_rdy <= 1'b0;
      case (state)
        IDLE: begin
          // A response cycle swallows the still-high request so it is not served twice.
          if (!is_jump && !if_rdy && if_req) begin
            if (hit) begin
              if_inst <= data_mem[req_index];
              if_rdy  <= 1'b1;
            end else if (!mem_needed) begin
              inst_needed <= 1'b1;
              inst_addr   <= {if_addr[ADDR_W-1:2], 2'b00};
              first_cycle <= 1'b1;
              state       <= FETCH;
            end
          end
        end
        FETCH: begin
          first_cycle <= 1'b0;
          // A completion pulse in the first cycle may belong to an aborted request.
          if (is_jump) begin
            inst_needed <= 1'b0;
            state       <= IDLE;
          end else if (inst_rdy && !first_cycle) begin
            valid[fill_index] <= 1'b1;
            if_inst           <= inst_data;
            if_rdy            <= 1'b1;
            inst_needed       <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level cache model.
module tb_icache;

  localparam int INDEX_W = 7;
  localparam int ADDR_W  = 32;
  localparam int LINES   = 1 << INDEX_W;

  logic        clk = 1'b0;
  logic        rst, is_jump, if_req, mem_needed, inst_rdy;
  logic [31:0] if_addr, inst_data;
  logic [31:0] if_inst, inst_addr;
  logic        if_rdy, inst_needed;

  int compared   = 0;
  int mismatched = 0;

  icache #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .is_jump(is_jump),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_rdy(if_rdy),
    .mem_needed(mem_needed), .inst_needed(inst_needed), .inst_addr(inst_addr),
    .inst_data(inst_data), .inst_rdy(inst_rdy)
  );

  always #5 clk = ~clk;

  // Reference model: lines keyed by word address, a busy flag and a count of cycles spent waiting.
  bit          model_ok = 1'b0;
  bit          busy;
  int          age;
  logic [31:0] lat_addr;
  bit          m_valid [LINES];
  logic [29:0] m_line  [LINES];
  logic [31:0] m_data  [LINES];
  logic        exp_rdy, exp_needed;
  logic [31:0] exp_inst, exp_addr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit prev_rdy;
    int idx;
    prev_rdy = exp_rdy;
    exp_rdy  = 1'b0;
    if (rst) begin
      model_ok = 1'b1;
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
      exp_inst = '0; exp_needed = 1'b0; exp_addr = '0; busy = 1'b0; age = 0;
    end else if (model_ok) begin
      if (!busy) begin
        idx = int'((if_addr >> 2) % LINES);
        if (!is_jump && !prev_rdy && if_req) begin
          if (m_valid[idx] && m_line[idx] == if_addr[31:2]) begin
            exp_inst = m_data[idx];
            exp_rdy  = 1'b1;
          end else if (!mem_needed) begin
            busy = 1'b1; age = 0;
            lat_addr   = {if_addr[31:2], 2'b00};
            exp_needed = 1'b1;
            exp_addr   = lat_addr;
          end
        end
      end else begin
        age++;
        if (is_jump) begin
          busy = 1'b0; exp_needed = 1'b0;
        end else if (inst_rdy && age > 1) begin
          idx = int'((lat_addr >> 2) % LINES);
          m_valid[idx] = 1'b1;
          m_line[idx]  = lat_addr[31:2];
          m_data[idx]  = inst_data;
          exp_inst = inst_data; exp_rdy = 1'b1; exp_needed = 1'b0; busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("cyc_if_rdy", 32'(if_rdy), 32'(exp_rdy));
      checkOutput("cyc_if_inst", if_inst, exp_inst);
      checkOutput("cyc_inst_needed", 32'(inst_needed), 32'(exp_needed));
      checkOutput("cyc_inst_addr", inst_addr, exp_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic jmp,
                               input logic mn, input logic rdy, input logic [31:0] data);
    if_req = req; if_addr = addr; is_jump = jmp;
    mem_needed = mn; inst_rdy = rdy; inst_data = data;
  endtask

  // Miss on addr, completion pulse driven during fetch cycle lat, then one idle gap.
  task automatic fetchMiss(input logic [31:0] addr, input int lat, input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("miss_needed", 32'(inst_needed), 32'd1);
    checkOutput("miss_addr", inst_addr, addr & 32'hFFFF_FFFC);
    for (int i = 1; i < lat; i++) begin
      tick();
      checkOutput("miss_wait_rdy", 32'(if_rdy), 32'd0);
    end
    inst_rdy = 1'b1; inst_data = data;
    tick();
    checkOutput("miss_if_rdy", 32'(if_rdy), 32'd1);
    checkOutput("miss_if_inst", if_inst, data);
    checkOutput("miss_needed_drop", 32'(inst_needed), 32'd0);
    applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic hitCheck(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("hit_if_rdy", 32'(if_rdy), 32'd1);
    checkOutput("hit_if_inst", if_inst, data);
    checkOutput("hit_needed", 32'(inst_needed), 32'd0);
    applyStimulus(1'b0, addr, 1'b0, 1'b0, 1'b0, '0);
    tick();
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic logic [31:0] pickAddr();
    logic [31:0] pool [8];
    pool = '{32'h0000_1004, 32'h0000_1204, 32'h0000_2000, 32'h0000_3000,
             32'h0000_0008, 32'h8000_0008, 32'h0000_4008, 32'hFFFF_FFFC};
    if ($urandom_range(0, 9) == 0) return $urandom;
    return pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int cnt;
    int target;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) tick();
    checkOutput("reset_if_rdy", 32'(if_rdy), 32'd0);
    checkOutput("reset_if_inst", if_inst, 32'd0);
    checkOutput("reset_needed", 32'(inst_needed), 32'd0);
    checkOutput("reset_inst_addr", inst_addr, 32'd0);
    rst = 1'b0;

    $display("[TB] cold miss, hit, conflict eviction");
    fetchMiss(32'h0000_1004, 6, 32'h00A0_0093);
    hitCheck(32'h0000_1004, 32'h00A0_0093);
    fetchMiss(32'h0000_1204, 2, 32'h1111_1111);
    fetchMiss(32'h0000_1004, 3, 32'h00A0_0093);
    checkOutput("evict_last_addr", inst_addr, 32'h0000_1004);

    $display("[TB] jump mid-fetch");
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0, '0);
    tick();
    checkOutput("jump_needed_on", 32'(inst_needed), 32'd1);
    tick();
    tick();
    is_jump = 1'b1;
    tick();
    checkOutput("jump_needed_off", 32'(inst_needed), 32'd0);
    checkOutput("jump_no_rdy", 32'(if_rdy), 32'd0);
    applyStimulus(1'b0, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    checkOutput("jump_late_rdy", 32'(if_rdy), 32'd0);
    inst_rdy = 1'b0;
    tick();
    fetchMiss(32'h0000_2000, 3, 32'h2222_2222);

    $display("[TB] memory contention");
    applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("contend_needed", 32'(inst_needed), 32'd0);
    end
    mem_needed = 1'b0;
    tick();
    checkOutput("contend_release", 32'(inst_needed), 32'd1);
    checkOutput("contend_addr", inst_addr, 32'h0000_3000);
    tick();
    inst_rdy = 1'b1; inst_data = 32'h3333_0000;
    tick();
    checkOutput("contend_if_inst", if_inst, 32'h3333_0000);
    applyStimulus(1'b0, 32'h0000_3000, 1'b0, 1'b0, 1'b0, '0);
    tick();

    $display("[TB] reset mid-fetch");
    applyStimulus(1'b1, 32'h0000_4008, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rst_mid_needed", 32'(inst_needed), 32'd0);
    checkOutput("rst_mid_if_rdy", 32'(if_rdy), 32'd0);
    rst = 1'b0;
    fetchMiss(32'h0000_1004, 2, 32'h00A0_0093);

    $display("[TB] randomized traffic");
    cnt = 0;
    target = $urandom_range(1, 6);
    applyStimulus(1'b1, pickAddr(), 1'b0, 1'b0, 1'b0, '0);
    for (int c = 0; c < 4000; c++) begin
      tick();
      inst_rdy = 1'b0;
      if (inst_needed) begin
        cnt++;
        if (cnt >= target) begin
          inst_rdy = 1'b1; inst_data = memWord(inst_addr);
          cnt = 0; target = $urandom_range(1, 6);
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 15) == 0) begin
          inst_rdy = 1'b1; inst_data = $urandom;
        end
      end
      rst        = ($urandom_range(0, 499) == 0);
      mem_needed = ($urandom_range(0, 3) == 0);
      is_jump    = ($urandom_range(0, 29) == 0);
      if (if_rdy || is_jump || !if_req) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = pickAddr();
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
